// File: rtl/mist1032isa_lsu_mem_master_pkg.sv
// Order encodings, read-metadata layout and lane helpers shared by the LSU memory master.
package mist1032isa_lsu_mem_master_pkg;

    typedef enum logic [1:0] {
        ORDER_BYTE = 2'b00,
        ORDER_HALF = 2'b01,
        ORDER_WORD = 2'b10,
        ORDER_NONE = 2'b11
    } order_e;

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_HOLD = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic [2:0] addr;
        logic [1:0] order;
        logic       sign;
    } meta_t;

    localparam int META_W = 6;

    function automatic logic cmd_legal(input logic [1:0] order, input logic [1:0] k);
        logic ok;
        ok = 1'b0;
        case (order)
            ORDER_BYTE: ok = 1'b1;
            ORDER_HALF: ok = !k[0];
            ORDER_WORD: ok = (k == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte offset k lives in word bits [31-8k : 24-8k], i.e. mask bit 3-k.
    function automatic logic [3:0] lane_mask(input logic [1:0] order, input logic [1:0] k);
        logic [3:0] m;
        m = 4'b0000;
        case (order)
            ORDER_BYTE: m = 4'b1000 >> k;
            ORDER_HALF: m = k[1] ? 4'b0011 : 4'b1100;
            ORDER_WORD: m = 4'b1111;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] order, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        case (order)
            ORDER_BYTE: r = {4{d[7:0]}};
            ORDER_HALF: r = {2{d[15:0]}};
            default:    r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [63:0] beat, input meta_t m);
        logic [31:0] w;
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] res;
        w = m.addr[2] ? beat[63:32] : beat[31:0];
        b = w[7:0];
        case (m.addr[1:0])
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = m.addr[1] ? w[15:0] : w[31:16];
        case (m.order)
            ORDER_BYTE: res = m.sign ? {{24{b[7]}}, b} : {24'h0, b};
            ORDER_HALF: res = m.sign ? {{16{h[15]}}, h} : {16'h0, h};
            default:    res = w;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mist1032isa_lsu_meta_fifo.sv
// Read-metadata FIFO: one entry per outstanding load, popped as responses return in order.
module mist1032isa_lsu_meta_fifo #(
    parameter int P_DEPTH = 4,
    parameter int P_WIDTH = 6,
    localparam int PTR_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1,
    localparam int CNT_W = $clog2(P_DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_push,
    input  logic [P_WIDTH-1:0] i_wdata,
    input  logic               i_pop,
    output logic [P_WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_full,
    output logic               o_empty
);

    logic [P_WIDTH-1:0] r_mem [P_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == CNT_W'(P_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mist1032isa_lsu_mem_master.sv
// LSU initiator for the 32-bit request / 64-bit response memory port: lane masks and
// replicated store data outbound, in-order aligned and extended load results inbound.
module mist1032isa_lsu_mem_master
    import mist1032isa_lsu_mem_master_pkg::*;
#(
    parameter int P_OUTSTANDING = 4,
    localparam int CNT_W = $clog2(P_OUTSTANDING) + 1
) (
    input  logic             iCLOCK,
    input  logic             iRESET_SYNC,
    input  logic             iCMD_REQ,
    output logic             oCMD_BUSY,
    input  logic             iCMD_RW,
    input  logic [1:0]       iCMD_ORDER,
    input  logic             iCMD_SIGNED,
    input  logic [31:0]      iCMD_ADDR,
    input  logic [31:0]      iCMD_DATA,
    output logic             oCMD_ERROR,
    output logic             oMEMORY_REQ,
    input  logic             iMEMORY_LOCK,
    output logic [1:0]       oMEMORY_ORDER,
    output logic [3:0]       oMEMORY_MASK,
    output logic             oMEMORY_RW,
    output logic [31:0]      oMEMORY_ADDR,
    output logic [31:0]      oMEMORY_DATA,
    input  logic             iMEMORY_VALID,
    output logic             oMEMORY_LOCK,
    input  logic [63:0]      iMEMORY_DATA,
    output logic             oLOAD_VALID,
    input  logic             iLOAD_LOCK,
    output logic [31:0]      oLOAD_DATA,
    output logic             oRESP_ERROR,
    output logic             oDEBUG_SLOT_STATE,
    output logic [CNT_W-1:0] oDEBUG_RD_COUNT
);

    // Handshakes: a command transfers when iCMD_REQ && !oCMD_BUSY; a request transfers
    // when oMEMORY_REQ && !iMEMORY_LOCK; a response beat transfers whenever iMEMORY_VALID
    // is high; a load result transfers when oLOAD_VALID && !iLOAD_LOCK.
    slot_state_e      r_state;
    slot_state_e      w_state_next;
    logic [1:0]       r_mem_order;
    logic [3:0]       r_mem_mask;
    logic             r_mem_rw;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_data;
    logic             r_cmd_error;
    logic             r_resp_error;
    logic             r_load_valid;
    logic [31:0]      r_load_data;

    logic             w_busy;
    logic             w_accept;
    logic             w_legal;
    logic             w_issue;
    logic             w_push;
    meta_t            w_push_meta;
    meta_t            w_pop_meta;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_full;
    logic             w_fifo_empty;

    assign w_push_meta = {iCMD_ADDR[2:0], iCMD_ORDER, iCMD_SIGNED};
    assign w_push      = w_issue && !iCMD_RW;

    mist1032isa_lsu_meta_fifo #(
        .P_DEPTH (P_OUTSTANDING),
        .P_WIDTH (META_W)
    ) u_meta_fifo (
        .i_clk   (iCLOCK),
        .i_reset (iRESET_SYNC),
        .i_push  (w_push),
        .i_wdata (w_push_meta),
        .i_pop   (iMEMORY_VALID),
        .o_rdata (w_pop_meta),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_state_next = r_state;
        w_busy       = ((r_state == SLOT_HOLD) && iMEMORY_LOCK) || w_fifo_full;
        w_accept     = iCMD_REQ && !w_busy;
        w_legal      = cmd_legal(iCMD_ORDER, iCMD_ADDR[1:0]);
        w_issue      = w_accept && w_legal;
        case (r_state)
            SLOT_IDLE: begin
                if (w_issue) begin
                    w_state_next = SLOT_HOLD;
                end
            end
            SLOT_HOLD: begin
                // A draining slot can be refilled in the same cycle.
                if (!iMEMORY_LOCK && !w_issue) begin
                    w_state_next = SLOT_IDLE;
                end
            end
            default: w_state_next = SLOT_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_state <= SLOT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_mem_order  <= 2'b00;
            r_mem_mask   <= 4'b0000;
            r_mem_rw     <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_data   <= 32'h0;
            r_cmd_error  <= 1'b0;
            r_resp_error <= 1'b0;
            r_load_valid <= 1'b0;
            r_load_data  <= 32'h0;
        end else begin
            r_cmd_error  <= w_accept && !w_legal;
            r_resp_error <= iMEMORY_VALID && w_fifo_empty;
            if (w_issue) begin
                r_mem_order <= iCMD_ORDER;
                r_mem_mask  <= lane_mask(iCMD_ORDER, iCMD_ADDR[1:0]);
                r_mem_rw    <= iCMD_RW;
                r_mem_addr  <= iCMD_ADDR;
                r_mem_data  <= lane_data(iCMD_ORDER, iCMD_DATA);
            end
            if (iMEMORY_VALID && !w_fifo_empty) begin
                r_load_valid <= 1'b1;
                r_load_data  <= load_extract(iMEMORY_DATA, w_pop_meta);
            end else if (r_load_valid && !iLOAD_LOCK) begin
                r_load_valid <= 1'b0;
            end
        end
    end

    assign oCMD_BUSY         = w_busy;
    assign oCMD_ERROR        = r_cmd_error;
    assign oMEMORY_REQ       = (r_state == SLOT_HOLD);
    assign oMEMORY_ORDER     = r_mem_order;
    assign oMEMORY_MASK      = r_mem_mask;
    assign oMEMORY_RW        = r_mem_rw;
    assign oMEMORY_ADDR      = r_mem_addr;
    assign oMEMORY_DATA      = r_mem_data;
    assign oMEMORY_LOCK      = r_load_valid && iLOAD_LOCK;
    assign oLOAD_VALID       = r_load_valid;
    assign oLOAD_DATA        = r_load_data;
    assign oRESP_ERROR       = r_resp_error;
    assign oDEBUG_SLOT_STATE = r_state;
    assign oDEBUG_RD_COUNT   = w_fifo_count;

endmodule

// File: doc/mist1032isa_lsu_mem_master.md
# mist1032isa_lsu_mem_master

Initiator side of the simulation memory request interface. It takes byte, half-word and word load/store commands from the core's load/store path and drives the 32-bit request / 64-bit response memory port. Toward memory it generates byte masks and lane-replicated store data. On the return path it tracks outstanding reads and delivers aligned, zero- or sign-extended 32-bit load results with backpressure.

## Interface
Parameters:
- P_OUTSTANDING, 4 — maximum reads issued and not yet returned (power of two, 2..16).

Ports. One clock; reset is synchronous and active-high.
- iCLOCK  in  1  clock.
- iRESET_SYNC  in  1  synchronous active-high reset.
- iCMD_REQ  in  1  command valid.
- oCMD_BUSY  out  1  command not accepted this cycle.
- iCMD_RW  in  1  1 = store, 0 = load.
- iCMD_ORDER  in  2  00 = byte, 01 = half-word, 10 = word, 11 = illegal.
- iCMD_SIGNED  in  1  sign-extend load result.
- iCMD_ADDR  in  32  byte address.
- iCMD_DATA  in  32  store data, right-aligned.
- oCMD_ERROR  out  1  one-cycle pulse: command rejected (misaligned or illegal order).
- oMEMORY_REQ  out  1  request valid.
- iMEMORY_LOCK  in  1  memory cannot take a request.
- oMEMORY_ORDER  out  2  copy of the command order.
- oMEMORY_MASK  out  4  byte enables.
- oMEMORY_RW  out  1  1 = write.
- oMEMORY_ADDR  out  32  byte address.
- oMEMORY_DATA  out  32  lane-replicated store data.
- iMEMORY_VALID  in  1  response beat; the beat is consumed whenever this is high.
- oMEMORY_LOCK  out  1  hold off responses.
- iMEMORY_DATA  in  64  response doubleword.
- oLOAD_VALID  out  1  load result valid.
- iLOAD_LOCK  in  1  consumer stall.
- oLOAD_DATA  out  32  load result.
- oRESP_ERROR  out  1  one-cycle pulse: response arrived with no read outstanding.

## Operation
- A command is accepted when iCMD_REQ && !oCMD_BUSY.
- oCMD_BUSY = (oMEMORY_REQ && iMEMORY_LOCK) || (outstanding count == P_OUTSTANDING). It applies to loads and stores alike.
- Alignment check on an accepted command:
  - half-word requires ADDR[0] = 0;
  - word requires ADDR[1:0] = 0;
  - ORDER 11 is always illegal.
  - A failing command produces an oCMD_ERROR pulse on the next cycle. No request is issued, no metadata is pushed, and the request slot is unchanged.
- Lane rule (k = ADDR[1:0]): the byte at offset k occupies word bits [31-8k : 24-8k], which is mask bit 3-k.
  - byte: MASK = 4'b1000 >> k; DATA = {4{d[7:0]}}.
  - half-word: MASK = ADDR[1] ? 4'b0011 : 4'b1100; DATA = {2{d[15:0]}}.
  - word: MASK = 4'b1111; DATA = d.
  - Loads drive the same mask; DATA is don't-care.
- Request slot FSM:
  - IDLE → HOLD on a legal accept.
  - HOLD → IDLE when !iMEMORY_LOCK, unless a new legal command is accepted in that cycle, in which case the slot stays in HOLD and reloads.
  - All oMEMORY_* outputs are stable while in HOLD with iMEMORY_LOCK high.
- Read metadata FIFO:
  - Each entry holds {ADDR[2:0], ORDER, SIGNED}.
  - An entry is pushed at accept time of a legal load and popped on iMEMORY_VALID.
  - A simultaneous push and pop leaves the count unchanged.
  - Responses return in order. Writes produce no response.
- Load extraction:
  - W = ADDR[2] ? R[63:32] : R[31:0].
  - byte = W[31-8k -: 8]; half-word = ADDR[1] ? W[15:0] : W[31:16]; word = W.
  - Zero-extend, or sign-extend when SIGNED.
- Output register:
  - A result is loaded on iMEMORY_VALID.
  - It is cleared on consume (oLOAD_VALID && !iLOAD_LOCK) when no new beat arrives in the same cycle.
  - oMEMORY_LOCK = oLOAD_VALID && iLOAD_LOCK, combinational from registered state.
- iMEMORY_VALID with an empty FIFO: the beat is dropped, the output register is unchanged, and oRESP_ERROR pulses.

## Timing
- Reset values:
  - oMEMORY_REQ = 0, oLOAD_VALID = 0, oCMD_ERROR = 0, oRESP_ERROR = 0;
  - count = 0, slot in IDLE, all data/address outputs = 0.
  - oCMD_BUSY and oMEMORY_LOCK evaluate to 0.
- Accept in cycle N → oMEMORY_REQ high in N+1.
- iMEMORY_VALID in cycle M → oLOAD_VALID and data in M+1.
- Back-to-back throughput is one command per cycle and one result per cycle.
- Reset mid-operation discards all state. Responses arriving after reset are spurious (dropped, oRESP_ERROR pulses).

## Structure
- Shared package:
  - order encodings ORDER_BYTE / ORDER_HALF / ORDER_WORD / ORDER_NONE;
  - metadata width constant;
  - mask lookup function;
  - extraction function.
- Sub-module mist1032isa_lsu_meta_fifo: synchronous-reset FIFO with P_OUTSTANDING depth, count/full/empty outputs, and wrap-around pointers.

## Test plan
Memory doubleword at address 0 = 0x89ABCDEF_01234567 (bits [63:32] = 0x89ABCDEF).
- Load byte, addr 1, unsigned → oMEMORY_MASK = 4'b0100, oLOAD_DATA = 0x00000023.
- Load byte, addr 4, signed → 0xFFFFFF89. Load half-word, addr 6, unsigned → 0x0000CDEF. Load word, addr 0 → 0x01234567.
- Store byte 0x5A, addr 2 → oMEMORY_MASK = 4'b0010, oMEMORY_DATA = 0x5A5A5A5A, oMEMORY_RW = 1, no response expected.
- Word command at addr 0x6 → oCMD_ERROR pulse, oMEMORY_REQ stays 0. ORDER = 11 → same response.
- Hold iMEMORY_LOCK high for 3 cycles during a request → oMEMORY_* outputs stable and oCMD_BUSY = 1. The request issues in the cycle the lock drops.
- Issue 4 loads with no response → oCMD_BUSY = 1. One iMEMORY_VALID → busy drops in the same cycle the count decrements.
- Hold iLOAD_LOCK high → oMEMORY_LOCK = 1 and oLOAD_DATA holds.
- Assert reset with 2 reads outstanding, then inject a response → beat dropped and oRESP_ERROR pulses.
